bram_port_responder: RTL

BRAM_PORT_RESPONDER -- requirements
Module: bram_port_responder

---
 rtl/bram_port_responder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bram_port_responder.sv
// Dual-port byte-enabled word memory with read-first collision handling,
// READ_LAT 1 or 2 read pipeline and sticky out-of-range error reporting.
//
// Ports:
//   Clk, Rst                 clock, synchronous active-high reset
//   PortX_En / PortX_Wen     access request and byte write enables (X = A, B)
//   PortX_Addr               byte address; word index = Addr[SYS_DWIDTH-1:2]
//   PortX_Data_To_Bram       write data
//   PortX_Data_From_Bram     read data, held until the next read completes
//   PortX_Rd_Valid           one-cycle pulse with each completed read
//   Err_Clear                clears Addr_Err / Err_Port
//   Addr_Err, Err_Port       sticky out-of-range flag and per-port record
module bram_port_responder #(
  parameter int SYS_DWIDTH = 32,
  parameter int BYTE_LEN   = 4,
  parameter int DEPTH      = 1024,
  parameter int READ_LAT   = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  PortA_En,
  input  logic [BYTE_LEN-1:0]   PortA_Wen,
  input  logic [SYS_DWIDTH-1:0] PortA_Addr,
  input  logic [SYS_DWIDTH-1:0] PortA_Data_To_Bram,
  output logic [SYS_DWIDTH-1:0] PortA_Data_From_Bram,
  output logic                  PortA_Rd_Valid,
  input  logic                  PortB_En,
  input  logic [BYTE_LEN-1:0]   PortB_Wen,
  input  logic [SYS_DWIDTH-1:0] PortB_Addr,
  input  logic [SYS_DWIDTH-1:0] PortB_Data_To_Bram,
  output logic [SYS_DWIDTH-1:0] PortB_Data_From_Bram,
  output logic                  PortB_Rd_Valid,
  input  logic                  Err_Clear,
  output logic                  Addr_Err,
  output logic [1:0]            Err_Port
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SYS_DWIDTH-1:0] L_DEPTH = SYS_DWIDTH'(DEPTH);

  logic [SYS_DWIDTH-1:0] r_mem [DEPTH];

  // Port 0 = A, port 1 = B
  logic [1:0]                 w_en;
  logic [1:0][BYTE_LEN-1:0]   w_wen;
  logic [1:0][SYS_DWIDTH-1:0] w_addr;
  logic [1:0][SYS_DWIDTH-1:0] w_wdata;

  assign w_en    = {PortB_En, PortA_En};
  assign w_wen   = {PortB_Wen, PortA_Wen};
  assign w_addr  = {PortB_Addr, PortA_Addr};
  assign w_wdata = {PortB_Data_To_Bram, PortA_Data_To_Bram};

  logic [1:0][SYS_DWIDTH-1:0] w_word;
  logic [1:0][AW-1:0]         w_idx;
  logic [1:0][SYS_DWIDTH-1:0] w_raw;
  logic [1:0][SYS_DWIDTH-1:0] w_rdata;
  logic [1:0]                 w_oor;
  logic [1:0]                 w_rd;
  logic [1:0]                 w_wr;
  logic [1:0]                 w_err_set;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_word[p]    = w_addr[p] >> 2;
      w_idx[p]     = w_word[p][AW-1:0];
      w_oor[p]     = (w_word[p] >= L_DEPTH);
      w_raw[p]     = r_mem[w_idx[p]];
      w_rdata[p]   = w_oor[p] ? '0 : w_raw[p];
      w_rd[p]      = !Rst && w_en[p] && (w_wen[p] == '0);
      w_wr[p]      = !Rst && w_en[p] && (w_wen[p] != '0) && !w_oor[p];
      w_err_set[p] = !Rst && w_en[p] && w_oor[p];
    end
  end

  // Same-word double write: A's merged word carries B's lanes too,
  // and is written last so A wins on shared lanes.
  logic                  w_same;
  logic [SYS_DWIDTH-1:0] w_na;
  logic [SYS_DWIDTH-1:0] w_nb;

  always_comb begin
    w_same = w_wr[1] && (w_idx[0] == w_idx[1]);
    w_na   = w_raw[0];
    w_nb   = w_raw[1];
    for (int l = 0; l < BYTE_LEN; l++) begin
      if (w_wen[1][l]) begin
        w_nb[l*8 +: 8] = w_wdata[1][l*8 +: 8];
      end
      if (w_same && w_wen[1][l]) begin
        w_na[l*8 +: 8] = w_wdata[1][l*8 +: 8];
      end
      if (w_wen[0][l]) begin
        w_na[l*8 +: 8] = w_wdata[0][l*8 +: 8];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (w_wr[1]) begin
      r_mem[w_idx[1]] <= w_nb;
    end
    if (w_wr[0]) begin
      r_mem[w_idx[0]] <= w_na;
    end
  end

  logic [1:0]                 r_s1_vld;
  logic [1:0][SYS_DWIDTH-1:0] r_s1_data;
  logic [1:0]                 r_vld;
  logic [1:0][SYS_DWIDTH-1:0] r_dout;
  logic [1:0]                 w_fin_vld;
  logic [1:0][SYS_DWIDTH-1:0] w_fin_data;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      if (READ_LAT == 1) begin
        w_fin_vld[p]  = w_rd[p];
        w_fin_data[p] = w_rdata[p];
      end else begin
        w_fin_vld[p]  = r_s1_vld[p];
        w_fin_data[p] = r_s1_data[p];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_s1_vld  <= '0;
      r_s1_data <= '0;
      r_vld     <= '0;
      r_dout    <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_s1_vld[p]  <= w_rd[p];
        r_s1_data[p] <= w_rdata[p];
        r_vld[p]     <= w_fin_vld[p];
        if (w_fin_vld[p]) begin
          r_dout[p] <= w_fin_data[p];
        end
      end
    end
  end

  logic       r_addr_err;
  logic [1:0] r_err_port;

  // New errors override a same-cycle clear
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_addr_err <= 1'b0;
      r_err_port <= 2'b00;
    end else begin
      r_addr_err <= (r_addr_err && !Err_Clear) || (|w_err_set);
      r_err_port <= (Err_Clear ? 2'b00 : r_err_port) | w_err_set;
    end
  end

  assign PortA_Data_From_Bram = r_dout[0];
  assign PortB_Data_From_Bram = r_dout[1];
  assign PortA_Rd_Valid       = r_vld[0];
  assign PortB_Rd_Valid       = r_vld[1];
  assign Addr_Err             = r_addr_err;
  assign Err_Port             = r_err_port;

endmodule
